// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the speculative store write buffer.
//   wb_ctrl_t      per-entry control bits (size, last-uop, committed)
//   size_to_mask   bytes-1 size code -> byte-enable mask
//   range_overlap  do two inclusive byte ranges share any byte
//   range_cover    does range S contain every byte of range L
// Ranges are handled in RANGE_W bits so that addr+size never wraps
// (ADDR_W must be at most RANGE_W-1).
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int SIZE_W    = 3;
  localparam int MAX_BYTES = 1 << SIZE_W;
  localparam int RANGE_W   = 32;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic              last;
    logic              cmt;
  } wb_ctrl_t;

  function automatic logic [MAX_BYTES-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (b <= int'(size)) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic range_overlap(input logic [RANGE_W-1:0] a_lo,
                                         input logic [SIZE_W-1:0]  a_size,
                                         input logic [RANGE_W-1:0] b_lo,
                                         input logic [SIZE_W-1:0]  b_size);
    logic [RANGE_W-1:0] a_hi;
    logic [RANGE_W-1:0] b_hi;
    a_hi = a_lo + RANGE_W'(a_size);
    b_hi = b_lo + RANGE_W'(b_size);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  function automatic logic range_cover(input logic [RANGE_W-1:0] s_lo,
                                       input logic [SIZE_W-1:0]  s_size,
                                       input logic [RANGE_W-1:0] l_lo,
                                       input logic [SIZE_W-1:0]  l_size);
    logic [RANGE_W-1:0] s_hi;
    logic [RANGE_W-1:0] l_hi;
    s_hi = s_lo + RANGE_W'(s_size);
    l_hi = l_lo + RANGE_W'(l_size);
    return (s_lo <= l_lo) && (l_hi <= s_hi);
  endfunction

endpackage

// File: rtl/wb_fwd_sel.sv
// ---------------------------------------------------------------------------
// wb_fwd_sel
// Picks the youngest matching entry of the circular buffer. Age order runs
// backwards from tail: tail-1 is the youngest, tail-DEPTH the oldest.
//   match  in   DEPTH   per-entry "valid and overlaps the load"
//   tail   in   PTR_W   next write slot of the buffer
//   hit    out  1       at least one entry matched
//   idx    out  PTR_W   index of the youngest matching entry (0 if none)
// ---------------------------------------------------------------------------
module wb_fwd_sel
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] tail,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] pos;

  // Walk from youngest to oldest; the first match found wins. For k=DEPTH
  // the cast wraps to 0, landing on tail itself, which is the oldest slot
  // when the buffer is full.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      pos = tail - PTR_W'(k);
      if (!hit && match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/wb_buffer_param.sv
// ---------------------------------------------------------------------------
// wb_buffer_param
// Speculative store write buffer between store execute and the D-cache.
// Stores enter uncommitted, are committed by EIP when their instruction
// retires, drain in program order once committed, and can be squashed by a
// flush while still uncommitted. Loads look up the youngest overlapping store
// for forwarding.
//   clk, rst              clock, synchronous active-high reset
//   enq, i_vld, i_eip, i_addr, i_data, i_size, i_last_uop   store enqueue
//   i_cmp_vld, i_eip_cmp  commit strobe and retiring EIP
//   i_flush               squash every uncommitted entry
//   read                  D-cache pops the head entry
//   i_ld_addr, i_ld_size  load lookup
//   o_en_*                head entry (masked to 0 when head invalid)
//   o_fwd_hit/data/stall  forwarding result
//   empty, full           occupancy flags
// DATA_W must be a multiple of 8 and at most 64; ADDR_W at most 31.
// ---------------------------------------------------------------------------
module wb_buffer_param
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int EIP_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic              i_vld,
  input  logic [EIP_W-1:0]  i_eip,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_last_uop,
  input  logic              i_cmp_vld,
  input  logic [EIP_W-1:0]  i_eip_cmp,
  input  logic              i_flush,
  input  logic              read,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [SIZE_W-1:0] i_ld_size,
  output logic              o_en_vld,
  output logic [ADDR_W-1:0] o_en_addr,
  output logic [DATA_W-1:0] o_en_data,
  output logic [EIP_W-1:0]  o_en_eip,
  output logic [SIZE_W-1:0] o_en_size,
  output logic              o_en_last,
  output logic              o_fwd_hit,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_fwd_stall,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NBYTES = DATA_W / 8;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  wb_ctrl_t          ctrl_q [DEPTH];
  wb_ctrl_t          ctrl_d [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [EIP_W-1:0]  eip_q  [DEPTH];
  logic [EIP_W-1:0]  eip_d  [DEPTH];

  logic              do_enq;
  logic              do_pop;
  logic              head_vld;
  logic [CNT_W-1:0]  cmt_cnt;

  logic [DEPTH-1:0]   ovl;
  logic               sel_any;
  logic [PTR_W-1:0]   sel_idx;
  logic [RANGE_W-1:0] ld_lo;
  logic [RANGE_W-1:0] sel_lo;
  logic [RANGE_W-1:0] shift_bits;
  logic [NBYTES-1:0]  ld_bmask;
  logic               sel_cover;
  logic [DATA_W-1:0]  fwd_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head_vld = vld_q[head_q];
  assign o_en_vld = head_vld && ctrl_q[head_q].cmt;
  assign do_pop   = read && o_en_vld;
  assign do_enq   = enq && i_vld && !full && !i_flush;

  assign o_en_addr = head_vld ? addr_q[head_q] : '0;
  assign o_en_data = head_vld ? data_q[head_q] : '0;
  assign o_en_eip  = head_vld ? eip_q[head_q]  : '0;
  assign o_en_size = head_vld ? ctrl_q[head_q].size : '0;
  assign o_en_last = head_vld && ctrl_q[head_q].last;

  // Next-state for pointers and entries. Commit is resolved first so that a
  // flush in the same cycle keeps the entries it just committed; the
  // committed count then tells the flush where the new tail lands. Entries
  // written this cycle are not yet valid, so they never see this commit.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    eip_d   = eip_q;
    cmt_cnt = '0;

    if (i_cmp_vld) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && !ctrl_q[i].cmt && (eip_q[i] == i_eip_cmp)) ctrl_d[i].cmt = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ctrl_d[i].cmt) cmt_cnt = cmt_cnt + CNT_W'(1);
    end

    if (do_pop) begin
      vld_d[head_q]      = 1'b0;
      ctrl_d[head_q].cmt = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end

    if (i_flush) begin
      // Committed entries are contiguous from head, so they all survive and
      // the tail folds back to just past them. A popped entry was counted
      // as committed, which is why the tail is measured from the old head.
      for (int i = 0; i < DEPTH; i++) begin
        if (!ctrl_d[i].cmt) vld_d[i] = 1'b0;
      end
      tail_d  = head_q + cmt_cnt[PTR_W-1:0];
      count_d = cmt_cnt - CNT_W'(do_pop);
    end else begin
      if (do_enq) begin
        vld_d[tail_q]  = 1'b1;
        ctrl_d[tail_q] = '{size: i_size, last: i_last_uop, cmt: 1'b0};
        addr_d[tail_q] = i_addr;
        data_d[tail_q] = i_data;
        eip_d[tail_q]  = i_eip;
        tail_d         = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_pop);
    end
  end

  // State registers. Reset clears everything, committed entries included.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        eip_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      eip_q   <= eip_d;
    end
  end

  assign ld_lo = RANGE_W'(i_ld_addr);

  // Overlap vector over all valid entries, committed or not.
  always_comb begin
    ovl = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ovl[i] = vld_q[i] && range_overlap(RANGE_W'(addr_q[i]), ctrl_q[i].size, ld_lo, i_ld_size);
    end
  end

  wb_fwd_sel #(.DEPTH(DEPTH)) u_fwd_sel (
    .match (ovl),
    .tail  (tail_q),
    .hit   (sel_any),
    .idx   (sel_idx)
  );

  // Forward only when the youngest overlapping store holds every load byte;
  // a partial overlap must stall because older data would be stale. The
  // shift is only meaningful when covered, since ld_lo >= sel_lo then.
  always_comb begin
    sel_lo     = RANGE_W'(addr_q[sel_idx]);
    sel_cover  = range_cover(sel_lo, ctrl_q[sel_idx].size, ld_lo, i_ld_size);
    shift_bits = (ld_lo - sel_lo) << 3;
    ld_bmask   = NBYTES'(size_to_mask(i_ld_size));
    fwd_data   = data_q[sel_idx] >> shift_bits;
    for (int b = 0; b < NBYTES; b++) begin
      if (!ld_bmask[b]) fwd_data[8*b +: 8] = '0;
    end
    o_fwd_hit   = sel_any && sel_cover;
    o_fwd_stall = sel_any && !sel_cover;
    o_fwd_data  = o_fwd_hit ? fwd_data : '0;
  end

endmodule
